ifm_line_buffer: RTL

IFM_LINE_BUFFER -- requirements
Module: ifm_line_buffer

---
 rtl/ifm_line_buffer.sv | 110 +++++++++++
 1 files changed

// File: rtl/ifm_line_buffer.sv
// Input feature-map line buffer: collects ksize*ksize matrix beats into a tile,
// then serves indexed reads until the last entry is fetched.
//
// state   | meaning
// --------+-----------------------------------------------
// S_EMPTY | no tile; waiting for first beat (samples ksize)
// S_FILL  | tile partially written; fill_level < n
// S_FULL  | tile complete; reads honoured, writes stalled
module ifm_line_buffer #(
  parameter int DEPTH = 25,
  parameter int DW    = 1024
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic [2:0]    ksize,
  input  logic          buf_clear,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  input  logic          fetch_en,
  input  logic [4:0]    fetch_num,
  output logic          ifm_buf_empty,
  output logic [DW-1:0] ifm_matrix_out,
  output logic [4:0]    fill_level,
  output logic          proto_err
);

  typedef enum logic [1:0] {S_EMPTY, S_FILL, S_FULL} state_t;

  state_t state, state_nxt;

  logic [DW-1:0] mem [DEPTH];
  logic [4:0]    n_lat;
  logic [4:0]    n_new;
  logic          ks_bad;
  logic          wr_fire;
  logic          wr_first_ok;
  logic          wr_en;
  logic [4:0]    wr_idx;
  logic          rd_ok;
  logic          rd_bad;
  logic          rd_last;

  assign n_new       = {2'b00, ksize} * {2'b00, ksize};
  assign ks_bad      = (ksize == 3'd0) || (ksize > 3'd5);
  assign wr_fire     = wr_valid && wr_ready && !buf_clear;
  assign wr_first_ok = wr_fire && (state == S_EMPTY) && !ks_bad;
  assign wr_en       = wr_first_ok || (wr_fire && (state == S_FILL));
  assign wr_idx      = (state == S_EMPTY) ? 5'd0 : fill_level;
  assign rd_ok       = fetch_en && !buf_clear && (state == S_FULL) && (fetch_num < n_lat);
  assign rd_bad      = fetch_en && !buf_clear && !((state == S_FULL) && (fetch_num < n_lat));
  assign rd_last     = rd_ok && (fetch_num == n_lat - 5'd1);

  // FSM: state register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= S_EMPTY;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_EMPTY: if (wr_first_ok) state_nxt = (n_new == 5'd1) ? S_FULL : S_FILL;
      S_FILL:  if (wr_fire && (fill_level + 5'd1 == n_lat)) state_nxt = S_FULL;
      S_FULL:  if (rd_last) state_nxt = S_EMPTY;
      default: state_nxt = S_EMPTY;
    endcase
    if (buf_clear) state_nxt = S_EMPTY;
  end

  // FSM: outputs
  always_comb begin
    wr_ready      = 1'b1;
    ifm_buf_empty = 1'b1;
    if (state == S_FULL) begin
      wr_ready      = 1'b0;
      ifm_buf_empty = 1'b0;
    end
  end

  // Tile storage needs no reset: reads are gated by S_FULL.
  always_ff @(posedge clock) begin
    if (wr_en && (int'(wr_idx) < DEPTH)) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      n_lat          <= 5'd0;
      fill_level     <= 5'd0;
      proto_err      <= 1'b0;
      ifm_matrix_out <= '0;
    end else if (buf_clear) begin
      fill_level <= 5'd0;
      proto_err  <= 1'b0;
    end else begin
      if (wr_first_ok) begin
        n_lat      <= n_new;
        fill_level <= 5'd1;
      end else if (wr_fire && (state == S_FILL)) begin
        fill_level <= fill_level + 5'd1;
      end else if (rd_last) begin
        fill_level <= 5'd0;
      end
      if (rd_bad || (wr_fire && (state == S_EMPTY) && ks_bad)) proto_err <= 1'b1;
      if (rd_ok) ifm_matrix_out <= mem[fetch_num];
    end
  end

endmodule
